// File: rtl/td_mac_accumulator_pkg.sv
// Shared definitions for the time-domain MAC accumulator.
// State encodings are fixed so the multiplier side can decode them in debug.
package td_mac_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/td_mac_accumulator_sat_adder.sv
// Combinational saturating unsigned adder: A_W-bit a plus B_W-bit b, clamps
// to all-ones on carry-out. Requires A_W > B_W.
module sat_adder #(
  parameter int A_W = 8,
  parameter int B_W = 2
) (
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic [A_W-1:0] o_sum,
  output logic           o_ovf
);

  logic [A_W:0] w_full;

  assign w_full = {1'b0, i_a} + {{(A_W + 1 - B_W){1'b0}}, i_b};
  assign o_ovf  = w_full[A_W];
  assign o_sum  = o_ovf ? {A_W{1'b1}} : w_full[A_W-1:0];

endmodule

// File: rtl/td_mac_accumulator.sv
// Sums VEC_LEN TDC product codes per frame into a saturating accumulator and
// hands the result out through a one-deep valid/ready buffer.
//
// state | meaning
// IDLE  | waiting for start; buffer may still hold the previous result
// ACC   | accepting products (prod_ready=1)
// HOLD  | frame done, final sum parked in acc until the buffer frees
module td_mac_accumulator
  import td_mac_accumulator_pkg::*;
#(
  parameter int N_BIT   = 2,
  parameter int ACC_W   = 8,
  parameter int VEC_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [N_BIT-1:0] i_prod_in,
  input  logic             i_prod_valid,
  output logic             o_prod_ready,
  output logic             o_busy,
  output logic [ACC_W-1:0] o_sum_out,
  output logic             o_sum_valid,
  input  logic             i_sum_ready,
  output logic             o_sat_flag,
  output logic             o_overrun
);

  localparam int               CNT_W    = $clog2(VEC_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [ACC_W-1:0] r_acc, r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fsat, r_sum_valid, r_sat, r_overrun;
  logic             w_accept, w_last, w_buf_free, w_load, w_add_ovf, w_load_sat;
  logic [ACC_W-1:0] w_add_sum, w_load_val;

  // Assert asynchronously, release on the second clk edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  sat_adder #(.A_W(ACC_W), .B_W(N_BIT)) u_sat_adder (
    .i_a   (r_acc),
    .i_b   (i_prod_in),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  assign w_accept   = i_prod_valid && (r_state == ST_ACC);
  assign w_last     = w_accept && (r_cnt == LAST_CNT);
  assign w_buf_free = !r_sum_valid || i_sum_ready;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = r_acc;
    w_load_sat  = r_fsat;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_ACC;
      ST_ACC: begin
        if (w_last) begin
          // Final product bypasses acc so the buffer loads on the last-accept edge.
          w_load_val = w_add_sum;
          w_load_sat = r_fsat | w_add_ovf;
          if (w_buf_free) begin
            w_load      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_buf_free) begin
          w_load      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_fsat      <= 1'b0;
      r_overrun   <= 1'b0;
      r_sum       <= '0;
      r_sat       <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_start) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_fsat    <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_accept) begin
        r_acc  <= w_add_sum;
        r_cnt  <= r_cnt + CNT_W'(1);
        r_fsat <= r_fsat | w_add_ovf;
      end
      if (r_state == ST_HOLD && i_prod_valid) r_overrun <= 1'b1;
      if (w_load) begin
        r_sum       <= w_load_val;
        r_sat       <= w_load_sat;
        r_sum_valid <= 1'b1;
      end else if (r_sum_valid && i_sum_ready) begin
        r_sum_valid <= 1'b0;
      end
    end
  end

  assign o_prod_ready = (r_state == ST_ACC);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_sum_out    = r_sum;
  assign o_sum_valid  = r_sum_valid;
  assign o_sat_flag   = r_sat;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_td_mac_accumulator.sv
// Bench for td_mac_accumulator: directed/table frames on a default instance,
// saturation and randomized backpressure on an ACC_W=4, VEC_LEN=8 instance.
module tb_td_mac_accumulator;

  logic       clk, rst_n;
  logic       a_start, a_prod_valid, a_prod_ready, a_busy, a_sum_valid, a_sum_ready, a_sat, a_ovr;
  logic [1:0] a_prod_in;
  logic [7:0] a_sum_out;
  logic       b_start, b_prod_valid, b_prod_ready, b_busy, b_sum_valid, b_sum_ready, b_sat, b_ovr;
  logic [1:0] b_prod_in;
  logic [3:0] b_sum_out;

  int errors = 0;
  int checks = 0;

  localparam int N_RAND = 30;
  int q_sum[$];
  int q_sat[$];
  int n_rx;

  td_mac_accumulator #(.N_BIT(2), .ACC_W(8), .VEC_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_prod_in(a_prod_in),
    .i_prod_valid(a_prod_valid), .o_prod_ready(a_prod_ready), .o_busy(a_busy),
    .o_sum_out(a_sum_out), .o_sum_valid(a_sum_valid), .i_sum_ready(a_sum_ready),
    .o_sat_flag(a_sat), .o_overrun(a_ovr)
  );

  td_mac_accumulator #(.N_BIT(2), .ACC_W(4), .VEC_LEN(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_prod_in(b_prod_in),
    .i_prod_valid(b_prod_valid), .o_prod_ready(b_prod_ready), .o_busy(b_busy),
    .o_sum_out(b_sum_out), .o_sum_valid(b_sum_valid), .i_sum_ready(b_sum_ready),
    .o_sat_flag(b_sat), .o_overrun(b_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame on dut_a, products back-to-back; returns at the negedge after the last accept.
  task automatic a_frame(input logic [7:0] prods);
    @(negedge clk);
    a_start = 1'b1; a_prod_valid = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_prod_valid = 1'b1; a_prod_in = prods[2*i +: 2];
      @(negedge clk);
    end
    a_prod_valid = 1'b0;
  endtask

  task automatic b_frame(input logic [15:0] prods);
    @(negedge clk);
    b_start = 1'b1; b_prod_valid = 1'b0;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_prod_valid = 1'b1; b_prod_in = prods[2*i +: 2];
      @(negedge clk);
    end
    b_prod_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] prods;   // {p3,p2,p1,p0}
    logic [7:0] exp_sum;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{prods: {2'd3, 2'd3, 2'd3, 2'd3}, exp_sum: 8'd12};
    tbl[1] = '{prods: {2'd0, 2'd0, 2'd0, 2'd0}, exp_sum: 8'd0};
    tbl[2] = '{prods: {2'd1, 2'd2, 2'd0, 2'd3}, exp_sum: 8'd6};
    tbl[3] = '{prods: {2'd2, 2'd2, 2'd2, 2'd1}, exp_sum: 8'd7};
    tbl[4] = '{prods: {2'd0, 2'd0, 2'd0, 2'd1}, exp_sum: 8'd1};
    tbl[5] = '{prods: {2'd3, 2'd0, 2'd3, 2'd0}, exp_sum: 8'd6};

    rst_n = 1'b0;
    a_start = 0; a_prod_valid = 0; a_prod_in = 0; a_sum_ready = 1;
    b_start = 0; b_prod_valid = 0; b_prod_in = 0; b_sum_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_sum_out", a_sum_out, 0);
    chk("rst_sum_valid", a_sum_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_prod_ready", a_prod_ready, 0);
    chk("rst_overrun", a_ovr, 0);
    chk("rst_sat", a_sat, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: 1,2,3,0 with latency check.
    a_prod_valid = 1'b1; a_prod_in = 2'd2;       // valid without start: dropped
    @(negedge clk);
    chk("idle_drop_overrun", a_ovr, 0);
    chk("idle_drop_busy", a_busy, 0);
    a_prod_valid = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("t1_prod_ready", a_prod_ready, 1);
    a_prod_valid = 1'b1; a_prod_in = 2'd1; @(negedge clk);
    a_prod_in = 2'd2; @(negedge clk);
    a_prod_in = 2'd3; @(negedge clk);
    a_prod_in = 2'd0;
    chk("t1_valid_before_last", a_sum_valid, 0);
    @(negedge clk);
    a_prod_valid = 1'b0;
    chk("t1_valid_after_last", a_sum_valid, 1);
    chk("t1_sum", a_sum_out, 6);
    chk("t1_sat", a_sat, 0);
    chk("t1_busy", a_busy, 0);
    @(negedge clk);
    chk("t1_valid_drained", a_sum_valid, 0);

    foreach (tbl[k]) begin
      a_frame(tbl[k].prods);
      chk($sformatf("tbl%0d_valid", k), a_sum_valid, 1);
      chk($sformatf("tbl%0d_sum", k), a_sum_out, tbl[k].exp_sum);
      chk($sformatf("tbl%0d_sat", k), a_sat, 0);
    end

    // Test 2: saturation on the narrow instance.
    b_frame({8{2'd3}});
    chk("t2_sat_sum", b_sum_out, 15);
    chk("t2_sat_flag", b_sat, 1);
    b_frame({8{2'd1}});
    chk("t2_nosat_sum", b_sum_out, 8);
    chk("t2_nosat_flag", b_sat, 0);

    // Test 3: backpressure, HOLD, overrun, back-to-back reload.
    @(negedge clk);
    a_sum_ready = 1'b0;
    a_frame({2'd3, 2'd3, 2'd3, 2'd3});
    chk("t3_a_valid", a_sum_valid, 1);
    chk("t3_a_sum", a_sum_out, 12);
    a_frame({2'd0, 2'd0, 2'd0, 2'd1});
    chk("t3_hold_busy", a_busy, 1);
    chk("t3_hold_ready", a_prod_ready, 0);
    chk("t3_hold_sum", a_sum_out, 12);
    a_prod_valid = 1'b1; a_prod_in = 2'd2;
    @(negedge clk);
    chk("t3_overrun", a_ovr, 1);
    chk("t3_still_hold", a_busy, 1);
    a_prod_valid = 1'b0; a_sum_ready = 1'b1;
    @(negedge clk);
    chk("t3_b2b_valid", a_sum_valid, 1);
    chk("t3_b2b_sum", a_sum_out, 1);
    chk("t3_idle", a_busy, 0);
    @(negedge clk);
    chk("t3_drained", a_sum_valid, 0);
    chk("t3_overrun_sticky", a_ovr, 1);

    // Test 4: gaps between products; garbage on prod_in while invalid.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("t4_overrun_cleared", a_ovr, 0);
    begin
      logic [2:0] seq [7];
      seq = '{3'b110, 3'b011, 3'b011, 3'b101, 3'b011, 3'b111, 3'b110};
      for (int i = 0; i < 7; i++) begin
        a_prod_valid = seq[i][2]; a_prod_in = seq[i][1:0];
        @(negedge clk);
      end
    end
    a_prod_valid = 1'b0;
    chk("t4_valid", a_sum_valid, 1);
    chk("t4_sum", a_sum_out, 8);

    // Test 5: reset mid-frame.
    a_start = 1'b1; @(negedge clk);
    a_start = 1'b0; a_prod_valid = 1'b1; a_prod_in = 2'd1; @(negedge clk);
    @(negedge clk);
    a_prod_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sum", a_sum_out, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_ready", a_prod_ready, 0);
    chk("t5_rst_valid", a_sum_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    a_frame({2'd1, 2'd1, 2'd1, 2'd1});
    chk("t5_after_rst_sum", a_sum_out, 4);

    // Test 6: product in the start cycle ignored; start in ACC ignored.
    @(negedge clk);
    a_start = 1'b1; a_prod_valid = 1'b1; a_prod_in = 2'd3;
    @(negedge clk);
    a_prod_in = 2'd1;                          // start still high while in ACC
    @(negedge clk);
    a_start = 1'b0;
    chk("t6_in_acc", a_prod_ready, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a_prod_valid = 1'b0;
    chk("t6_sum", a_sum_out, 4);
    chk("t6_valid", a_sum_valid, 1);

    // Randomized frames with gaps and random consumer backpressure on dut_b.
    n_rx = 0;
    fork
      begin : drv
        for (int f = 0; f < N_RAND; f++) begin
          int tot, acc_cnt, guard;
          logic [1:0] p;
          logic v;
          guard = 0;
          @(negedge clk);
          while (b_busy && guard < 200) begin
            @(negedge clk);
            guard++;
          end
          chk("rand_idle_wait", b_busy, 0);
          b_start = 1'b1; b_prod_valid = 1'b0;
          @(negedge clk);
          b_start = 1'b0;
          tot = 0; acc_cnt = 0; guard = 0;
          while (acc_cnt < 8 && guard < 400) begin
            p = 2'($urandom);
            v = (($urandom % 3) != 0) && b_prod_ready;
            b_prod_valid = v; b_prod_in = p;
            if (v) begin
              acc_cnt++;
              tot += int'(p);
            end
            guard++;
            @(negedge clk);
          end
          b_prod_valid = 1'b0;
          chk("rand_frame_done", acc_cnt, 8);
          q_sum.push_back(tot > 15 ? 15 : tot);
          q_sat.push_back(tot > 15 ? 1 : 0);
        end
      end
      begin : con
        int cyc;
        cyc = 0;
        while (n_rx < N_RAND && cyc < 5000) begin
          @(negedge clk);
          b_sum_ready = 1'($urandom);
          #1;
          if (b_sum_valid && b_sum_ready) begin
            if (q_sum.size() == 0) begin
              chk("rand_unexpected_result", 1, 0);
            end else begin
              chk($sformatf("rand%0d_sum", n_rx), b_sum_out, q_sum.pop_front());
              chk($sformatf("rand%0d_sat", n_rx), b_sat, q_sat.pop_front());
            end
            n_rx++;
          end
          cyc++;
        end
        chk("rand_result_count", n_rx, N_RAND);
      end
    join
    chk("rand_overrun", b_ovr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
